// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the shared-adder arbiter.
// State encodings, ID width and datapath width.
package adder_share_arbiter_pkg;
  localparam int ID_W    = 2;
  localparam int MAX_REQ = 4;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/adder_share_arbiter_adder.sv
// 8-bit ripple adder built from half/full adder cells.
// Bit 0 uses a half adder; the 9th result bit is the carry out.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] r
);
  logic [7:0] c;

  half_adder u_ha (
    .a  (a[0]),
    .b  (b[0]),
    .s  (r[0]),
    .co (c[0])
  );

  for (genvar i = 1; i < 8; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i-1]),
      .s  (r[i]),
      .co (c[i])
    );
  end

  assign r[8] = c[7];
endmodule

// File: rtl/adder_share_arbiter_rr_pick.sv
// Round-robin picker: first valid request at or after the pointer.
// Purely combinational; wraps modulo NUM_REQ.
module rr_pick
  import adder_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);
  int idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any_req  = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one ripple adder between NUM_REQ requesters.
// Round-robin grant, latched operands, registered 9-bit sum.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [DATA_W*NUM_REQ-1:0] reqA,
  input  logic [DATA_W*NUM_REQ-1:0] reqB,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic                      rspValid,
  output logic [ID_W-1:0]           rspId,
  output logic [8:0]                rspR,
  input  logic                      rspReady,
  output logic                      busy
);
  state_t              state;
  logic [ID_W-1:0]     rrPtr;
  logic [ID_W-1:0]     winId;
  logic [DATA_W-1:0]   opA;
  logic [DATA_W-1:0]   opB;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                any_req;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [8:0]          sum;
  logic [ID_W-1:0]     next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (reqValid),
    .rr_ptr    (rrPtr),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_req   (any_req)
  );

  ripple_adder8 u_add (
    .a (opA),
    .b (opB),
    .r (sum)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a = reqA[i*DATA_W +: DATA_W];
        sel_b = reqB[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (winId == ID_W'(NUM_REQ - 1)) ?
                    '0 : ID_W'(winId + 1'b1);

  // Grant is only offered while idle and out of reset.
  assign reqReady = (state == ST_IDLE && !rst) ? grant : '0;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rrPtr    <= '0;
      winId    <= '0;
      opA      <= '0;
      opB      <= '0;
      rspR     <= '0;
      rspId    <= '0;
      rspValid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            opA   <= sel_a;
            opB   <= sel_b;
            winId <= grant_id;
            state <= ST_ADD;
          end
        end
        ST_ADD: begin
          rspR     <= sum;
          rspId    <= winId;
          rspValid <= 1'b1;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rspReady) begin
            rspValid <= 1'b0;
            rrPtr    <= next_ptr;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with NUM_REQ=2.
// Each scenario task drives vectors and checks inline.
module tb_adder_share_arbiter;
  logic        clk;
  logic        rst;
  logic [1:0]  reqValid;
  logic [15:0] reqA;
  logic [15:0] reqB;
  logic [1:0]  reqReady;
  logic        rspValid;
  logic [1:0]  rspId;
  logic [8:0]  rspR;
  logic        rspReady;
  logic        busy;

  int checks = 0;
  int errors = 0;

  adder_share_arbiter #(
    .NUM_REQ (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reqValid (reqValid),
    .reqA     (reqA),
    .reqB     (reqB),
    .reqReady (reqReady),
    .rspValid (rspValid),
    .rspId    (rspId),
    .rspR     (rspR),
    .rspReady (rspReady),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqValid = 2'b01;
    reqA = 16'h0011;
    reqB = 16'h0022;
    rspReady = 1'b0;
    tick();
    tick();
    checks++;
    if (rspValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rspValid got %b want 0", rspValid);
    end
    checks++;
    if (rspR !== 9'h000 || rspId !== 2'd0) begin
      errors++;
      $display("FAIL reset_rsp got r=%h id=%0d want 000/0", rspR, rspId);
    end
    checks++;
    if (busy !== 1'b0 || reqReady !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got busy=%b rdy=%b want 0/00", busy, reqReady);
    end
    reqValid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single();
    reqValid = 2'b01;
    reqA = 16'h003C;
    reqB = 16'h0005;
    #1;
    checks++;
    if (reqReady !== 2'b01) begin
      errors++;
      $display("FAIL single_ready got %b want 01", reqReady);
    end
    tick();
    reqValid = 2'b00;
    #1;
    checks++;
    if (rspValid !== 1'b0 || busy !== 1'b1 || reqReady !== 2'b00) begin
      errors++;
      $display("FAIL single_add got v=%b busy=%b rdy=%b want 0/1/00",
               rspValid, busy, reqReady);
    end
    tick();
    checks++;
    if (rspValid !== 1'b1 || rspR !== 9'h041 || rspId !== 2'd0) begin
      errors++;
      $display("FAIL single_rsp got v=%b r=%h id=%0d want 1/041/0",
               rspValid, rspR, rspId);
    end
    rspReady = 1'b1;
    tick();
    checks++;
    if (rspValid !== 1'b0 || rspR !== 9'h041 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got v=%b r=%h busy=%b want 0/041/0",
               rspValid, rspR, busy);
    end
  endtask

  task automatic test_carry();
    logic [7:0] va [3] = '{8'hFF, 8'h80, 8'h00};
    logic [7:0] vb [3] = '{8'hFF, 8'h80, 8'h00};
    logic [8:0] vr [3] = '{9'h1FE, 9'h100, 9'h000};
    rspReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      reqValid = 2'b01;
      reqA = {8'h00, va[i]};
      reqB = {8'h00, vb[i]};
      tick();
      reqValid = 2'b00;
      tick();
      checks++;
      if (rspValid !== 1'b1 || rspR !== vr[i]) begin
        errors++;
        $display("FAIL carry_%0d got v=%b r=%h want 1/%h",
                 i, rspValid, rspR, vr[i]);
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rspReady = 1'b1;
    reqValid = 2'b11;
    reqA = 16'h1001;
    reqB = 16'h2002;
    for (int g = 0; g < 4; g++) begin
      #1;
      checks++;
      if (reqReady !== ((g % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL fair_grant_%0d got %b", g, reqReady);
      end
      tick();
      checks++;
      if (reqReady !== 2'b00) begin
        errors++;
        $display("FAIL fair_add_%0d got rdy=%b want 00", g, reqReady);
      end
      tick();
      checks++;
      if (rspValid !== 1'b1 || rspId !== 2'(g % 2) ||
          rspR !== ((g % 2 == 0) ? 9'h003 : 9'h030)) begin
        errors++;
        $display("FAIL fair_rsp_%0d got v=%b id=%0d r=%h",
                 g, rspValid, rspId, rspR);
      end
      tick();
    end
    reqValid = 2'b00;
  endtask

  task automatic test_backpressure();
    rspReady = 1'b0;
    reqValid = 2'b01;
    reqA = 16'h227F;
    reqB = 16'h3301;
    #1;
    checks++;
    if (reqReady !== 2'b01) begin
      errors++;
      $display("FAIL bp_grant got %b want 01", reqReady);
    end
    tick();
    reqValid = 2'b10;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rspValid !== 1'b1 || rspR !== 9'h080 || rspId !== 2'd0 ||
          reqReady !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b r=%h id=%0d rdy=%b busy=%b",
                 c, rspValid, rspR, rspId, reqReady, busy);
      end
      tick();
    end
    rspReady = 1'b1;
    tick();
    checks++;
    if (reqReady !== 2'b10 || rspValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_next got rdy=%b v=%b want 10/0", reqReady, rspValid);
    end
    tick();
    reqValid = 2'b00;
    tick();
    checks++;
    if (rspValid !== 1'b1 || rspR !== 9'h055 || rspId !== 2'd1) begin
      errors++;
      $display("FAIL bp_req1 got v=%b r=%h id=%0d want 1/055/1",
               rspValid, rspR, rspId);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rspReady = 1'b1;
    reqValid = 2'b01;
    reqA = 16'hAA01;
    reqB = 16'h0101;
    tick();
    reqValid = 2'b00;
    tick();
    tick();
    reqValid = 2'b10;
    #1;
    checks++;
    if (reqReady !== 2'b10) begin
      errors++;
      $display("FAIL rm_grant got %b want 10", reqReady);
    end
    tick();
    reqValid = 2'b00;
    rst = 1'b1;
    tick();
    checks++;
    if (rspValid !== 1'b0 || rspR !== 9'h000 || rspId !== 2'd0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_clear got v=%b r=%h id=%0d busy=%b want 0/000/0/0",
               rspValid, rspR, rspId, busy);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rspValid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rm_stray_%0d got v=%b busy=%b want 0/0",
                 c, rspValid, busy);
      end
    end
    reqValid = 2'b11;
    #1;
    checks++;
    if (reqReady !== 2'b01) begin
      errors++;
      $display("FAIL rm_ptr got %b want 01", reqReady);
    end
    reqValid = 2'b00;
    tick();
  endtask

  task automatic test_withdrawn();
    rspReady = 1'b1;
    reqValid = 2'b01;
    reqA = 16'h5512;
    reqB = 16'h6634;
    tick();
    reqValid = 2'b10;
    #1;
    checks++;
    if (reqReady !== 2'b00) begin
      errors++;
      $display("FAIL wd_add got rdy=%b want 00", reqReady);
    end
    tick();
    reqValid = 2'b00;
    #1;
    checks++;
    if (rspValid !== 1'b1 || rspR !== 9'h046 || rspId !== 2'd0) begin
      errors++;
      $display("FAIL wd_rsp got v=%b r=%h id=%0d want 1/046/0",
               rspValid, rspR, rspId);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (reqReady !== 2'b00 || busy !== 1'b0 || rspValid !== 1'b0) begin
        errors++;
        $display("FAIL wd_idle_%0d got rdy=%b busy=%b v=%b want 00/0/0",
                 c, reqReady, busy, rspValid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
